// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg
//   Shared definitions for the instruction-sequencing controller:
//   state encoding (also the OutState debug code), opcode values and
//   ALU function selects.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Opcode -> first execute state. Unassigned opcodes behave as NOOP.
  function automatic state_t exec_state(input logic [3:0] opcode);
    case (opcode)
      OP_NOOP:  return S_NOOP;
      OP_STORE: return S_STORE;
      OP_LOAD:  return S_LOAD_A;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_HALT:  return S_HALT;
      default:  return S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode
//   Moore output decode for control_fsm: pure combinational function of
//   the current state and the instruction operand fields.
//   Ports:
//     state      in  4   current FSM state (control_fsm_pkg::state_t code)
//     IR         in  12  operand fields IR[11:0]; the opcode nibble is only
//                        needed by the next-state logic, so it is not routed here
//     PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
//     RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState   out  datapath controls
module control_decode
  import control_fsm_pkg::*;
(
  input  logic [3:0]  state,
  input  logic [11:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  OutState
);

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'd0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    ALU_s0     = ALU_PASS;
    OutState   = state;

    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // Data memory has one cycle of read latency: LOAD_A presents the
      // address, LOAD_B holds it and commits the returned word.
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = IR[11:4];
        RF_s      = 1'b1;
        RF_W_addr = IR[3:0];
        RF_W_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm
//   Instruction-sequencing controller: fetch, decode and execute of a
//   small load/store/add/sub ISA. Moore machine; outputs come from
//   control_decode.
//   Ports:
//     Clk   in   1   system clock, rising edge
//     Clr   in   1   asynchronous active-high reset to INIT
//     IR    in   16  current instruction, opcode = IR[15:12]
//     PC_clr, PC_up, IR_ld, D_addr[8], D_wr, RF_s, RF_W_addr[4], RF_W_en,
//     RF_Ra_addr[4], RF_Rb_addr[4], ALU_s0[3]   out  datapath controls
//     OutState  out  4   current state code for debug display
//
//   state  | meaning
//   INIT   | clear PC, wait for first edge after reset
//   FETCH  | load IR and advance PC (only state that pulses PC_up)
//   DECODE | dispatch on opcode
//   NOOP   | no operation (also any unassigned opcode)
//   LOAD_A | present data address, wait for read data
//   LOAD_B | write read data into register file
//   STORE  | write register A to data memory
//   ADD    | RF[W] = RF[A] + RF[B]
//   SUB    | RF[W] = RF[A] - RF[B]
//   HALT   | idle until reset
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        Clk,
  input  logic        Clr,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  OutState
);

  state_t state;
  state_t state_next;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = exec_state(IR[15:12]);
      S_NOOP:   state_next = S_FETCH;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_ADD:    state_next = S_FETCH;
      S_SUB:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_INIT;
    endcase
  end

  control_decode u_decode (
    .state      (state),
    .IR         (IR[11:0]),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .OutState   (OutState)
  );

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  localparam int HALT_HOLD = 10;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [15:0] IR  = 16'h0000;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
  logic [2:0]  ALU_s0;

  control_fsm dut (
    .Clk(Clk), .Clr(Clr), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .OutState(OutState)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic [3:0] st;
  } obs_t;

  obs_t        sb[$];
  logic [15:0] prog_q[$];
  int          pidx = 0;
  int          checks = 0;
  int          failures = 0;
  int          pc_up_cnt = 0;
  bit          mon_en = 0;
  bit          feed_en = 0;

  function automatic obs_t sample();
    return {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
            RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState};
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // Reference behaviour of one instruction, from the cycle after its fetch
  // through the fetch of the next instruction (HALT never fetches again).
  task automatic push_instr(input logic [15:0] ir);
    obs_t e;
    logic [3:0] op;
    op = ir[15:12];
    sb.push_back(blank(4'd2));
    case (op)
      4'd1: begin
        e = blank(4'd6); e.d_addr = ir[7:0]; e.ra = ir[11:8]; e.d_wr = 1'b1;
        sb.push_back(e);
      end
      4'd2: begin
        e = blank(4'd4); e.d_addr = ir[11:4]; e.rf_s = 1'b1; e.w_addr = ir[3:0];
        sb.push_back(e);
        e.st = 4'd5; e.w_en = 1'b1;
        sb.push_back(e);
      end
      4'd3, 4'd4: begin
        e = blank((op == 4'd3) ? 4'd7 : 4'd8);
        e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0];
        e.alu = (op == 4'd3) ? 3'd1 : 3'd2; e.w_en = 1'b1;
        sb.push_back(e);
      end
      4'd5: begin
        repeat (HALT_HOLD) sb.push_back(blank(4'd9));
        return;
      end
      default: sb.push_back(blank(4'd3));
    endcase
    e = blank(4'd1); e.pc_up = 1'b1; e.ir_ld = 1'b1;
    sb.push_back(e);
  endtask

  // Instruction register / memory model: loads on the edge that ends FETCH.
  always begin
    @(negedge Clk);
    if (feed_en && IR_ld && pidx < prog_q.size()) begin
      @(posedge Clk);
      #1;
      IR = prog_q[pidx];
      pidx++;
      push_instr(IR);
    end
  end

  // Monitor: one Moore output vector per cycle, checked against the queue.
  always @(negedge Clk) begin
    obs_t o, x;
    if (mon_en) begin
      o = sample();
      if (o.pc_up) pc_up_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got %h, required an expected entry", o);
      end else begin
        x = sb.pop_front();
        if (o !== x) begin
          failures++;
          $display("FAIL cycle_out t=%0t: got %h required %h", $time, o, x);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Clr is held by the caller; checks INIT outputs, releases, arms scoreboard.
  task automatic release_reset(input logic [15:0] prog[$]);
    obs_t e;
    prog_q = prog;
    pidx = 0;
    pc_up_cnt = 0;
    sb.delete();
    @(negedge Clk);
    check("clr_held_outputs", 64'(sample()), 64'(blank(4'd0) | {1'b1, 32'd0}));
    e = blank(4'd1); e.pc_up = 1'b1; e.ir_ld = 1'b1;
    sb.push_back(e);
    Clr = 1'b0;
    #1;
    mon_en = 1;
    feed_en = 1;
  endtask

  task automatic run_program(input logic [15:0] prog[$]);
    bit done;
    release_reset(prog);
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge Clk);
      #1;
      done = (pidx == prog.size()) && (sb.size() == 0);
    end
    mon_en = 0;
    feed_en = 0;
    check("program_done", 64'(done), 64'd1);
    check("pc_up_count", 64'(pc_up_cnt), 64'(prog.size()));
    check("halt_state", 64'(OutState), 64'd9);
    @(posedge Clk);
    #3;
    Clr = 1'b1;
    #1;
    check("async_clr_state", 64'(OutState), 64'd0);
    check("async_clr_pc_clr", 64'(PC_clr), 64'd1);
  endtask

  // Start an instruction, assert Clr asynchronously inside target state.
  task automatic abort_test(input logic [15:0] ir, input logic [3:0] target);
    logic [15:0] p[$];
    bit hit;
    p.push_back(ir);
    release_reset(p);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge Clk);
      #1;
      hit = (OutState == target);
    end
    mon_en = 0;
    feed_en = 0;
    sb.delete();
    check("abort_reached_state", 64'(hit), 64'd1);
    Clr = 1'b1;
    #1;
    check("abort_state", 64'(OutState), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_no_write", 64'({D_wr, RF_W_en, PC_clr}), 64'b001);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    if (op >= 4'd5) op = op + 4'd1;
    return {op, 12'($urandom)};
  endfunction

  initial begin
    logic [15:0] p[$];

    repeat (2) @(negedge Clk);
    check("reset_state", 64'(OutState), 64'd0);
    check("reset_pc_clr", 64'(PC_clr), 64'd1);

    // Directed: load, add, sub, store, illegal, halt.
    p = '{16'h2A53, 16'h3123, 16'h4123, 16'h1C07, 16'hF000, 16'h5000};
    run_program(p);

    // Five instructions including the halt.
    p.delete();
    repeat (4) p.push_back(rand_instr());
    p.push_back({4'd5, 12'($urandom)});
    run_program(p);

    // Longer random program.
    p.delete();
    repeat (25) p.push_back(rand_instr());
    p.push_back(16'h5ABC);
    run_program(p);

    abort_test(16'h2A53, 4'd4);
    abort_test(16'h1C07, 4'd6);

    // Mid-cycle asynchronous Clr from FETCH.
    p = '{16'h5000};
    release_reset(p);
    @(posedge Clk);
    #3;
    mon_en = 0;
    feed_en = 0;
    Clr = 1'b1;
    #1;
    check("midcycle_clr_state", 64'(OutState), 64'd0);
    check("midcycle_clr_outputs", 64'(sample()), 64'(blank(4'd0) | {1'b1, 32'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Clr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port IR  input  16  current instruction word from the instruction register; opcode = IR[15:12].
REQ-004 SHALL have port PC_clr  output  1  clears the program counter.
REQ-005 SHALL have port PC_up  output  1  advances the program counter by one.
REQ-006 SHALL have port IR_ld  output  1  loads the instruction register from instruction memory.
REQ-007 SHALL have port D_addr  output  8  data-memory address.
REQ-008 SHALL have port D_wr  output  1  data-memory write enable.
REQ-009 SHALL have port RF_s  output  1  register-file write-data select: 1 = data memory, 0 = ALU.
REQ-010 SHALL have port RF_W_addr  output  4  register-file write address.
REQ-011 SHALL have port RF_W_en  output  1  register-file write enable.
REQ-012 SHALL have port RF_Ra_addr  output  4  register-file read port A address.
REQ-013 SHALL have port RF_Rb_addr  output  4  register-file read port B address.
REQ-014 SHALL have port ALU_s0  output  3  ALU function select: 0 = pass A, 1 = add, 2 = subtract.
REQ-015 SHALL have port OutState  output  4  encoding of the current state, for debug display.

Function
REQ-016 SHALL implement a Moore FSM with states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-017 Outputs SHALL be decoded combinationally from the current state and IR only. Every output not listed for a state SHALL be 0.
REQ-018 INIT: PC_clr=1; next state FETCH.
REQ-019 FETCH: IR_ld=1 and PC_up=1, asserted together for exactly one cycle; next state DECODE.
REQ-020 DECODE: all outputs 0. Next state by opcode: 0000 -> NOOP, 0001 -> STORE, 0010 -> LOAD_A, 0011 -> ADD, 0100 -> SUB, 0101 -> HALT.
REQ-021 DECODE SHALL send any other opcode (0110-1111) to NOOP.
REQ-022 NOOP: all outputs 0; next state FETCH.
REQ-023 LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0; next state LOAD_B.
REQ-024 LOAD_B: same as LOAD_A but RF_W_en=1; next state FETCH.
REQ-025 LOAD is two cycles because data-memory read latency is one cycle.
REQ-026 STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1; next state FETCH.
REQ-027 ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1; next state FETCH.
REQ-028 SUB: identical to ADD except ALU_s0=2.
REQ-029 HALT: all outputs 0 and PC_up never asserted; the FSM SHALL remain in HALT until Clr.
REQ-030 Instruction cycle lengths: NOOP 3, STORE 3, ADD 3, SUB 3, LOAD 4 cycles, each counted from FETCH entry.
REQ-031 PC_up SHALL never be asserted outside FETCH, so the PC advances exactly once per instruction.
REQ-032 PC wrap-around (7-bit) is owned by the counter; control_fsm SHALL be unaffected by it.
REQ-033 OutState encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.

Reset
REQ-034 Clr=1 SHALL force the state to INIT immediately, independent of Clk.
REQ-035 While Clr=1, outputs SHALL be the INIT values: PC_clr=1, all other outputs 0, OutState=0.
REQ-036 Clr asserted mid-instruction (e.g. in LOAD_A or STORE) SHALL abort that instruction with no D_wr or RF_W_en pulse.
REQ-037 After Clr deasserts, the first rising edge SHALL move the FSM INIT -> FETCH.

Structure
REQ-038 A shared package SHALL hold the state enum (4-bit, values per REQ-033), the opcode constants and the ALU select constants.
REQ-039 The output decode SHALL be one combinational sub-module, control_decode(state, IR).
REQ-040 The state register and next-state logic SHALL remain in control_fsm.

Verification
REQ-041 Reset: Clr=1 asynchronously mid-cycle -> state 0 and PC_clr=1 at once. Release -> OutState sequence 1, 2.
REQ-042 LOAD: IR=16'h2A53 -> LOAD_A: D_addr=8'hA5, RF_W_addr=3, RF_s=1, RF_W_en=0. LOAD_B: RF_W_en=1. Then FETCH.
REQ-043 ADD/SUB: IR=16'h3123 -> Ra=1, Rb=2, W=3, ALU_s0=1, W_en=1. IR=16'h4123 -> same with ALU_s0=2.
REQ-044 STORE: IR=16'h1C07 -> RF_Ra_addr=12, D_addr=8'h07, D_wr=1 for exactly one cycle.
REQ-045 Illegal/NOOP/HALT: IR=16'hF000 -> NOOP, then FETCH. IR=16'h5000 -> HALT held 10 cycles with PC_up=0 throughout. Then Clr -> INIT.
REQ-046 Count check: run 5 instructions -> exactly 5 PC_up pulses, each coincident with IR_ld.
